// File: rtl/result_mux_5to1.sv
// Write-back result selector: combinational mux + illegal-select flag (0 cycles), optional captured copy and sticky error (1 cycle).
// No handshake or back-pressure; the registered copy loads only when i_en is high.
module result_mux_5to1 #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_arstn,
  input  logic [2:0]            i_control_signal,
  input  logic [DATA_WIDTH-1:0] i_mux_0,
  input  logic [DATA_WIDTH-1:0] i_mux_1,
  input  logic [DATA_WIDTH-1:0] i_mux_2,
  input  logic [DATA_WIDTH-1:0] i_mux_3,
  input  logic [DATA_WIDTH-1:0] i_mux_4,
  input  logic                  i_en,
  input  logic                  i_clr_err,
  output logic [DATA_WIDTH-1:0] o_mux,
  output logic [DATA_WIDTH-1:0] o_mux_q,
  output logic                  o_sel_err,
  output logic                  o_sel_err_sticky
);

  // Unmatched selects (5..7, or X in simulation) fall to the zero default.
  always_comb begin
    o_mux = '0;
    case (i_control_signal)
      3'd0:    o_mux = i_mux_0;
      3'd1:    o_mux = i_mux_1;
      3'd2:    o_mux = i_mux_2;
      3'd3:    o_mux = i_mux_3;
      3'd4:    o_mux = i_mux_4;
      default: o_mux = '0;
    endcase
  end

  assign o_sel_err = (i_control_signal > 3'd4);

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      o_mux_q <= '0;
    end else if (i_en) begin
      o_mux_q <= o_mux;
    end
  end

  // Set wins over clear so an error in the clearing cycle is never lost.
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      o_sel_err_sticky <= 1'b0;
    end else if (o_sel_err) begin
      o_sel_err_sticky <= 1'b1;
    end else if (i_clr_err) begin
      o_sel_err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_result_mux_5to1.sv
// Directed bench for result_mux_5to1 with a per-cycle reference model and literal spot checks.
module tb_result_mux_5to1;
  localparam int DW = 64;

  logic          i_clk;
  logic          i_arstn;
  logic [2:0]    i_control_signal;
  logic [DW-1:0] src [5];
  logic          i_en;
  logic          i_clr_err;
  logic [DW-1:0] o_mux;
  logic [DW-1:0] o_mux_q;
  logic          o_sel_err;
  logic          o_sel_err_sticky;

  int tests = 0;
  int fails = 0;
  bit cmp_on = 0;

  logic [DW-1:0] m_q;
  logic          m_sticky;

  result_mux_5to1 #(.DATA_WIDTH(DW)) dut (
    .i_clk            (i_clk),
    .i_arstn          (i_arstn),
    .i_control_signal (i_control_signal),
    .i_mux_0          (src[0]),
    .i_mux_1          (src[1]),
    .i_mux_2          (src[2]),
    .i_mux_3          (src[3]),
    .i_mux_4          (src[4]),
    .i_en             (i_en),
    .i_clr_err        (i_clr_err),
    .o_mux            (o_mux),
    .o_mux_q          (o_mux_q),
    .o_sel_err        (o_sel_err),
    .o_sel_err_sticky (o_sel_err_sticky)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [DW-1:0] exp_mux(input logic [2:0] s);
    if (s < 3'd5) return src[s];
    return '0;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference state: what the two registers must hold after each edge.
  always @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      m_q      <= '0;
      m_sticky <= 1'b0;
    end else begin
      if (i_en) m_q <= exp_mux(i_control_signal);
      if (i_control_signal >= 3'd5) m_sticky <= 1'b1;
      else if (i_clr_err) m_sticky <= 1'b0;
    end
  end

  always @(posedge i_clk) begin
    #1;
    if (cmp_on) begin
      chk("model_mux", o_mux, exp_mux(i_control_signal));
      chk("model_err", DW'(o_sel_err), DW'(i_control_signal >= 3'd5));
      chk("model_q", o_mux_q, m_q);
      chk("model_sticky", DW'(o_sel_err_sticky), DW'(m_sticky));
    end
  end

  task automatic step;
    @(posedge i_clk);
    #2;
  endtask

  task automatic drive(input logic [2:0] s, input logic en, input logic clr);
    @(negedge i_clk);
    i_control_signal = s;
    i_en             = en;
    i_clr_err        = clr;
    #1;
  endtask

  initial begin
    logic [DW-1:0] walk [5];
    logic [DW-1:0] pat;
    logic [DW-1:0] e;
    walk[0] = 64'h0A; walk[1] = 64'h1B; walk[2] = 64'h2C; walk[3] = 64'h3D; walk[4] = 64'h4E;

    i_arstn = 1'b0;
    i_control_signal = 3'd0;
    i_en = 1'b0;
    i_clr_err = 1'b0;
    for (int k = 0; k < 5; k++) src[k] = walk[k];
    #3;
    chk("reset_q", o_mux_q, '0);
    chk("reset_sticky", DW'(o_sel_err_sticky), '0);
    chk("reset_mux_live", o_mux, 64'h0A);
    @(negedge i_clk);
    i_arstn = 1'b1;
    cmp_on = 1;

    // Select walk: value visible in the same cycle, no error.
    for (int k = 0; k < 5; k++) begin
      drive(3'(k), 1'b0, 1'b0);
      chk("walk_mux", o_mux, walk[k]);
      chk("walk_err", DW'(o_sel_err), '0);
    end

    // Illegal selects.
    for (int k = 5; k < 8; k++) begin
      drive(3'(k), 1'b0, 1'b0);
      chk("illegal_mux", o_mux, '0);
      chk("illegal_err", DW'(o_sel_err), 64'h1);
      step();
      chk("illegal_sticky", DW'(o_sel_err_sticky), 64'h1);
    end

    // Capture then hold.
    src[3] = 64'hDEADBEEF_CAFEF00D;
    drive(3'd3, 1'b1, 1'b0);
    step();
    chk("capture_q", o_mux_q, 64'hDEADBEEF_CAFEF00D);
    src[3] = 64'h1234;
    drive(3'd3, 1'b0, 1'b0);
    step();
    chk("hold_q_a", o_mux_q, 64'hDEADBEEF_CAFEF00D);
    drive(3'd0, 1'b0, 1'b0);
    step();
    chk("hold_q_b", o_mux_q, 64'hDEADBEEF_CAFEF00D);

    // Illegal capture loads zero.
    drive(3'd6, 1'b1, 1'b0);
    step();
    chk("capture_illegal_q", o_mux_q, '0);

    // Sticky: set beats clear, then clear with a legal select.
    drive(3'd6, 1'b0, 1'b1);
    step();
    chk("clr_vs_set", DW'(o_sel_err_sticky), 64'h1);
    drive(3'd1, 1'b0, 1'b1);
    step();
    chk("clr_legal", DW'(o_sel_err_sticky), '0);

    // Async reset between edges.
    src[0] = '1;
    drive(3'd0, 1'b1, 1'b0);
    step();
    chk("preset_q", o_mux_q, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(3'd7, 1'b0, 1'b0);
    step();
    chk("preset_sticky", DW'(o_sel_err_sticky), 64'h1);
    drive(3'd2, 1'b1, 1'b0);
    i_arstn = 1'b0;
    #1;
    chk("arst_q", o_mux_q, '0);
    chk("arst_sticky", DW'(o_sel_err_sticky), '0);
    chk("arst_mux_live", o_mux, 64'h2C);
    i_control_signal = 3'd5;
    #1;
    chk("arst_err_live", DW'(o_sel_err), 64'h1);
    step();
    chk("arst_hold_q", o_mux_q, '0);
    chk("arst_hold_sticky", DW'(o_sel_err_sticky), '0);
    @(negedge i_clk);
    i_arstn = 1'b1;
    drive(3'd4, 1'b1, 1'b0);
    step();
    chk("post_reset_capture", o_mux_q, 64'h4E);

    // All-ones / all-zeros on each input in turn, others inverted.
    for (int p = 0; p < 2; p++) begin
      pat = (p == 0) ? '1 : '0;
      for (int k = 0; k < 5; k++) begin
        for (int j = 0; j < 5; j++) src[j] = ~pat;
        src[k] = pat;
        for (int s = 0; s < 8; s++) begin
          drive(3'(s), 1'b1, 1'b0);
          if (s == k) e = pat;
          else if (s < 5) e = ~pat;
          else e = '0;
          chk("pattern_mux", o_mux, e);
        end
      end
    end

    step();
    cmp_on = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
